// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Mode-0 SPI bus master (CPOL=0, CPHA=0, MSB first). It uses the same byte-bus
// handshake as spi_slave. Back-to-back bytes can be sent under a single
// spi_ss assertion by holding `start` high at the burst decision point, which
// is the cycle of the last falling edge of a frame.
//
// Parameters
//   WIDTH : bits per frame (2 or more)
//   HALF  : clk cycles per spi_clk half-period (2 or more)
//   GAP   : clk cycles spi_ss stays high after a frame before a new start is
//           accepted (1 or more)
//
// Ports
//   clk     in  : system clock
//   rst     in  : synchronous reset, active-high
//   ena     in  : clock enable; while low, every register holds
//   start   in  : transfer request (sampled in IDLE and at the burst decision)
//   bus_in  in  : byte to transmit, captured on a tx cycle
//   bus_out out : last received byte, updated on the rx cycle
//   tx      out : one-cycle pulse, bus_in captured this cycle
//   rx      out : one-cycle pulse, bus_out updated this cycle
//   busy    out : high from the cycle after acceptance until the GAP wait ends
//   spi_clk out : serial clock, idles low
//   spi_ss  out : slave select, active low
//   spi_out out : MOSI
//   spi_in  in  : MISO
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int WIDTH = 8,
  parameter int HALF  = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             tx,
  output logic             rx,
  output logic             busy,
  output logic             spi_clk,
  output logic             spi_ss,
  output logic             spi_out,
  input  logic             spi_in
);

  // One shared divider serves the spi_clk half-periods, the END hold and the
  // GAP wait, so it must reach the larger of HALF and GAP.
  localparam int CNT_MAX = (HALF > GAP) ? HALF : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_END   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  // High for exactly one enabled cycle: the cycle in which the WIDTH-th
  // falling edge is visible on spi_clk. rx and the burst decision key off it.
  logic             last_fall;

  logic half_done;
  logic rise_ev;
  logic fall_ev;
  logic sample_ev;
  logic load_ev;

  assign half_done = (cnt == HALF_LAST);
  assign rise_ev   = (state == S_SHIFT) && !spi_clk && half_done && !last_fall;
  assign fall_ev   = (state == S_SHIFT) &&  spi_clk && half_done;
  // MISO is taken in the first cycle spi_clk is visibly high, i.e. the value
  // present at the rising edge on the pin.
  assign sample_ev = (state == S_SHIFT) &&  spi_clk && (cnt == '0);
  // Capture bus_in either on an IDLE accept or at the burst decision point.
  assign load_ev   = start && ((state == S_IDLE) ||
                               ((state == S_SHIFT) && last_fall));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // Without a burst request the frame closes; with one we stay here
        // and the reload happens in the datapath.
        if (last_fall && !start) state_nxt = S_END;
      end
      S_END: begin
        if (half_done) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (state != S_IDLE);
    spi_ss  = !((state == S_SHIFT) || (state == S_END));
    // tx_sr shifts in zeros, so after the last falling edge spi_out is
    // already 0 for the END hold.
    spi_out = ((state == S_SHIFT) || (state == S_END)) ? tx_sr[WIDTH-1] : 1'b0;
    // Strobes are suppressed while disabled; last_fall and the IDLE/decision
    // condition hold, so the pulse appears once ena returns.
    tx      = ena && !rst && load_ev;
    rx      = ena && !rst && last_fall;
  end

  // ---------------------------------------------------------------------------
  // Shared divider
  // ---------------------------------------------------------------------------
  // The cycle of the last falling edge counts as the first cycle of both the
  // END hold and a burst's first low phase, so the count simply runs on.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      case (state)
        S_SHIFT, S_END: cnt <= half_done ? '0 : cnt + 1'b1;
        S_GAP:          cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
        default:        cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serial datapath: spi_clk, shift registers, bit count, bus_out
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_clk   <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      last_fall <= 1'b0;
      bus_out   <= '0;
    end else if (ena) begin
      last_fall <= fall_ev && (bit_cnt == BIT_LAST);

      if (rise_ev) begin
        spi_clk <= 1'b1;
      end

      if (sample_ev) begin
        rx_sr <= {rx_sr[WIDTH-2:0], spi_in};
      end

      if (fall_ev) begin
        spi_clk <= 1'b0;
        tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        // All WIDTH samples are in rx_sr by the last falling edge.
        if (bit_cnt == BIT_LAST) begin
          bus_out <= rx_sr;
        end
      end

      // Never coincides with fall_ev: a load happens in IDLE or in the cycle
      // after the last falling edge, when spi_clk is already low.
      if (load_ev) begin
        tx_sr   <= bus_in;
        bit_cnt <= '0;
      end
    end
  end

endmodule
